// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC-3 datapath blocks: the default datapath width,
// the instruction-fetch FSM state type and the 4-bit opcode encodings found in
// IR[15:12].
// -----------------------------------------------------------------------------
package lc3_pkg;

    localparam int unsigned LC3_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_ADDR = 3'd1,
        FETCH_WAIT = 3'd2,
        LOAD_IR    = 3'd3,
        HOLD       = 3'd4
    } fetch_state_t;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

endpackage

// File: rtl/ir_fetch_unit.sv
// -----------------------------------------------------------------------------
// ir_fetch_unit
// Instruction fetch stage of the 16-bit LC-3 datapath. Holds PC, MAR, MDR and
// IR, sequences one memory read per instruction and hands the latched IR to
// decode with a valid/ack handshake. The raw immediate/offset fields are sliced
// here so the downstream sign extenders connect straight to this block.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   Run                  start fetching from IDLE
//   Halt                 with ir_ack: return to IDLE instead of fetching next
//   mem_req/mem_addr     read request and address (MAR)
//   mem_rdy/mem_rdata    read data valid / read data
//   ir_valid/ir_ack      IR handshake towards decode
//   pc_ld/pc_in          PC redirect (branch/jump target)
//   pc_out               current PC (already past the fetched instruction)
//   ir_out, ir_opcode, ir_imm5, ir_off6, ir_off9, ir_off11   IR and its fields
//   fetch_err            one-cycle pulse on memory timeout
// -----------------------------------------------------------------------------
module ir_fetch_unit
    import lc3_pkg::*;
#(
    parameter int unsigned       WIDTH    = LC3_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       WAIT_MAX = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Halt,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_rdy,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             ir_valid,
    input  logic             ir_ack,
    input  logic             pc_ld,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] ir_out,
    output logic [3:0]       ir_opcode,
    output logic [4:0]       ir_imm5,
    output logic [5:0]       ir_off6,
    output logic [8:0]       ir_off9,
    output logic [10:0]      ir_off11,
    output logic             fetch_err
);

    // Last wait-counter value before the read is declared lost.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic             w_timeout;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_ir;
    logic [7:0]       r_wait_cnt;
    logic             r_fetch_err;

    // Next-state logic. A ready on the final allowed wait cycle is tested
    // first, so it wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (Run) begin
                    w_state_nxt = FETCH_ADDR;
                end
            end
            FETCH_ADDR: begin
                w_state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rdy) begin
                    w_state_nxt = LOAD_IR;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            LOAD_IR: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (ir_ack) begin
                    w_state_nxt = Halt ? IDLE : FETCH_ADDR;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_ir        <= '0;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_err <= w_timeout;
            case (r_state)
                IDLE: begin
                    // A load in the same cycle as Run is seen by FETCH_ADDR,
                    // so the fetch starts from pc_in.
                    if (pc_ld) begin
                        r_pc <= pc_in;
                    end
                end
                FETCH_ADDR: begin
                    r_mar      <= r_pc;
                    r_pc       <= r_pc + WIDTH'(1);
                    r_wait_cnt <= '0;
                end
                FETCH_WAIT: begin
                    if (mem_rdy) begin
                        r_mdr <= mem_rdata;
                    end else if (w_timeout) begin
                        // Undo the increment so the lost instruction is
                        // fetched again on the next Run.
                        r_pc <= r_mar;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                LOAD_IR: begin
                    r_ir <= r_mdr;
                end
                HOLD: begin
                    if (ir_ack && pc_ld) begin
                        r_pc <= pc_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = (r_state == FETCH_WAIT);
    assign ir_valid  = (r_state == HOLD);
    assign mem_addr  = r_mar;
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign fetch_err = r_fetch_err;

    // Raw fields only; sign extension happens in the downstream units.
    assign ir_opcode = r_ir[15:12];
    assign ir_imm5   = r_ir[4:0];
    assign ir_off6   = r_ir[5:0];
    assign ir_off9   = r_ir[8:0];
    assign ir_off11  = r_ir[10:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ir_fetch_unit
// Directed bench for ir_fetch_unit. The stimulus thread pushes the expected
// request address, delivered instruction (with hand-computed fields) or
// timeout PC into queues; a monitor on the falling edge pops and compares
// whenever the DUT raises mem_req, ir_valid or fetch_err.
// -----------------------------------------------------------------------------
module tb_ir_fetch_unit;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  opcode;
        logic [4:0]  imm5;
        logic [5:0]  off6;
        logic [8:0]  off9;
        logic [10:0] off11;
        logic [15:0] pc;
    } instr_exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Halt = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rdy = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        ir_valid;
    logic        ir_ack = 1'b0;
    logic        pc_ld = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] pc_out;
    logic [15:0] ir_out;
    logic [3:0]  ir_opcode;
    logic [4:0]  ir_imm5;
    logic [5:0]  ir_off6;
    logic [8:0]  ir_off9;
    logic [10:0] ir_off11;
    logic        fetch_err;

    int checks = 0;
    int passes = 0;

    logic [15:0] q_addr[$];
    instr_exp_t  q_ir[$];
    logic [15:0] q_err[$];

    ir_fetch_unit #(
        .WIDTH    (16),
        .RESET_PC (16'h0000),
        .WAIT_MAX (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Halt      (Halt),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack),
        .pc_ld     (pc_ld),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .ir_opcode (ir_opcode),
        .ir_imm5   (ir_imm5),
        .ir_off6   (ir_off6),
        .ir_off9   (ir_off9),
        .ir_off11  (ir_off11),
        .fetch_err (fetch_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Run = 1'b0; Halt = 1'b0; ir_ack = 1'b0; pc_ld = 1'b0; mem_rdy = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Called right after the inputs that start a fetch have been driven.
    // Serves the read 'delay' cycles after mem_req rises and returns the number
    // of edges until ir_valid and the number of cycles mem_req was high.
    task automatic wait_instr(input logic [15:0] data, input int delay,
                              output int lat, output int reqc);
        lat = 0;
        reqc = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            Run = 1'b0; ir_ack = 1'b0; pc_ld = 1'b0; Halt = 1'b0;
            lat++;
            if (mem_req) begin
                reqc++;
                mem_rdy = (reqc == delay + 1);
                mem_rdata = data;
            end else begin
                mem_rdy = 1'b0;
            end
            if (ir_valid) break;
        end
        mem_rdy = 1'b0;
        if (!ir_valid) chk("instr_wait_bound", 32'(ir_valid), 32'd1);
    endtask

    // Scoreboard monitor
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_vld = 1'b0;
        logic [15:0] cur_addr = 16'h0000;
        instr_exp_t  e;
        forever begin
            @(negedge Clk);
            if (mem_req && !prev_req) begin
                if (q_addr.size() == 0) chk("unexpected_mem_req", 32'd1, 32'd0);
                else begin
                    cur_addr = q_addr.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
                end
            end else if (mem_req) begin
                chk("mem_addr_hold", 32'(mem_addr), 32'(cur_addr));
            end
            if (ir_valid && !prev_vld) begin
                if (q_ir.size() == 0) chk("unexpected_ir_valid", 32'd1, 32'd0);
                else begin
                    e = q_ir.pop_front();
                    chk("ir_out",    32'(ir_out),    32'(e.ir));
                    chk("ir_opcode", 32'(ir_opcode), 32'(e.opcode));
                    chk("ir_imm5",   32'(ir_imm5),   32'(e.imm5));
                    chk("ir_off6",   32'(ir_off6),   32'(e.off6));
                    chk("ir_off9",   32'(ir_off9),   32'(e.off9));
                    chk("ir_off11",  32'(ir_off11),  32'(e.off11));
                    chk("pc_out",    32'(pc_out),    32'(e.pc));
                end
            end
            if (fetch_err) begin
                if (q_err.size() == 0) chk("unexpected_fetch_err", 32'd1, 32'd0);
                else chk("err_pc_out", 32'(pc_out), 32'(q_err.pop_front()));
            end
            prev_req = mem_req;
            prev_vld = ir_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int reqc;
        int seen;

        // Reset state
        do_reset();
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_ir_valid",  32'(ir_valid),  32'd0);
        chk("rst_pc_out",    32'(pc_out),    32'h0000);
        chk("rst_ir_out",    32'(ir_out),    32'h0000);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0000);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);

        // Basic fetch, ready on the first wait cycle
        q_addr.push_back(16'h0000);
        q_ir.push_back('{16'h1A7F, 4'h1, 5'h1F, 6'h3F, 9'h07F, 11'h27F, 16'h0001});
        Run = 1'b1;
        wait_instr(16'h1A7F, 0, lat, reqc);
        chk("latency_first", 32'(lat), 32'd4);

        // pc_ld without ack is ignored
        pc_ld = 1'b1; pc_in = 16'h3000;
        step();
        step();
        chk("hold_pc_ignored", 32'(pc_out),   32'h0001);
        chk("hold_valid",      32'(ir_valid), 32'd1);
        chk("hold_ir_stable",  32'(ir_out),   32'h1A7F);

        // Redirect on acknowledge, back-to-back latency
        q_addr.push_back(16'h3000);
        q_ir.push_back('{16'h5020, 4'h5, 5'h00, 6'h20, 9'h020, 11'h020, 16'h3001});
        ir_ack = 1'b1;
        wait_instr(16'h5020, 0, lat, reqc);
        chk("latency_b2b", 32'(lat), 32'd4);

        // Slow memory: ready three cycles late
        do_reset();
        q_addr.push_back(16'h0000);
        q_ir.push_back('{16'hE5A3, 4'hE, 5'h03, 6'h23, 9'h1A3, 11'h5A3, 16'h0001});
        Run = 1'b1;
        wait_instr(16'hE5A3, 3, lat, reqc);
        chk("latency_slow",  32'(lat),  32'd7);
        chk("req_cycles_slow", 32'(reqc), 32'd4);

        // Timeout: memory never answers
        do_reset();
        q_addr.push_back(16'h0000);
        q_err.push_back(16'h0000);
        Run = 1'b1;
        reqc = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            Run = 1'b0;
            if (mem_req) reqc++;
            if (fetch_err) begin
                seen = 1;
                break;
            end
        end
        chk("timeout_seen",       32'(seen),     32'd1);
        chk("timeout_req_cycles", 32'(reqc),     32'd8);
        chk("timeout_idle_req",   32'(mem_req),  32'd0);
        chk("timeout_idle_valid", 32'(ir_valid), 32'd0);
        step();
        chk("fetch_err_width",    32'(fetch_err), 32'd0);
        chk("timeout_stays_idle", 32'(mem_req),   32'd0);

        // Refetch of the lost instruction
        q_addr.push_back(16'h0000);
        q_ir.push_back('{16'hF025, 4'hF, 5'h05, 6'h25, 9'h025, 11'h025, 16'h0001});
        Run = 1'b1;
        wait_instr(16'hF025, 0, lat, reqc);
        chk("latency_refetch", 32'(lat), 32'd4);

        // PC wrap, with ready on the last allowed wait cycle
        q_addr.push_back(16'hFFFF);
        q_ir.push_back('{16'h0E02, 4'h0, 5'h02, 6'h02, 9'h002, 11'h602, 16'h0000});
        ir_ack = 1'b1; pc_ld = 1'b1; pc_in = 16'hFFFF;
        wait_instr(16'h0E02, 7, lat, reqc);
        chk("latency_last_wait",   32'(lat),  32'd11);
        chk("req_cycles_lastwait", 32'(reqc), 32'd8);

        // Halt on acknowledge
        ir_ack = 1'b1; Halt = 1'b1;
        step();
        ir_ack = 1'b0; Halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("halt_mem_req",  32'(mem_req),  32'd0);
            chk("halt_ir_valid", 32'(ir_valid), 32'd0);
            step();
        end

        // Reset in the middle of a read, late ready must be ignored
        q_addr.push_back(16'h0000);
        Run = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            Run = 1'b0;
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        chk("midfetch_req_seen", 32'(seen), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_rdy = 1'b0;
        chk("midrst_mem_req",   32'(mem_req),   32'd0);
        chk("midrst_ir_valid",  32'(ir_valid),  32'd0);
        chk("midrst_pc_out",    32'(pc_out),    32'h0000);
        chk("midrst_mem_addr",  32'(mem_addr),  32'h0000);
        chk("midrst_fetch_err", 32'(fetch_err), 32'd0);
        step();
        step();
        step();
        chk("midrst_ir_out",     32'(ir_out),   32'h0000);
        chk("midrst_ir_valid_2", 32'(ir_valid), 32'd0);
        chk("midrst_mem_req_2",  32'(mem_req),  32'd0);

        step();
        chk("q_addr_drained", 32'(q_addr.size()), 32'd0);
        chk("q_ir_drained",   32'(q_ir.size()),   32'd0);
        chk("q_err_drained",  32'(q_err.size()),  32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
